// File: rtl/arb_grant_mux.sv
// arb_grant_mux: captures the granted payload from a single-cycle
// arbiter into a 2-entry {id, data} FIFO with a valid/ready output.
module arb_grant_mux #(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         gnt_i,
  input  logic [N*W-1:0]       data_i,
  output logic [N-1:0]         ack_o,
  output logic                 out_valid_o,
  output logic [W-1:0]         out_data_o,
  output logic [$clog2(N)-1:0] out_id_o,
  input  logic                 out_ready_i,
  output logic [1:0]           level_o,
  output logic                 err_o
);

  localparam int ID_W = $clog2(N);

  logic [W-1:0]    mem_d [2];
  logic [ID_W-1:0] mem_id [2];
  logic            wptr;
  logic            rptr;
  logic [1:0]      count;
  logic            err_q;

  logic            any_gnt;
  logic            onehot;
  logic            multi;
  logic            push;
  logic            pop;
  logic [ID_W-1:0] sel_id;
  logic [W-1:0]    sel_d;

  // Classify the grant: a power of two is one-hot, anything else
  // non-zero is multi-hot.
  always_comb begin
    any_gnt = |gnt_i;
    onehot  = any_gnt && ((gnt_i & (gnt_i - N'(1))) == '0);
    multi   = any_gnt && !onehot;
  end

  // Encode the granted index and pick its payload slice.
  always_comb begin
    sel_id = '0;
    sel_d  = '0;
    for (int k = 0; k < N; k++) begin
      if (gnt_i[k]) begin
        sel_id = sel_id | ID_W'(k);
        sel_d  = sel_d | data_i[k*W +: W];
      end
    end
  end

  // Push/pop decisions; ack never looks at the consumer's ready.
  always_comb begin
    push  = onehot && (count != 2'd2) && !reset;
    pop   = (count != 2'd0) && out_ready_i;
    ack_o = push ? gnt_i : '0;
  end

  // Storage write; cleared on reset so the head reads zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_d[0]  <= '0;
      mem_d[1]  <= '0;
      mem_id[0] <= '0;
      mem_id[1] <= '0;
    end else if (push) begin
      mem_d[wptr]  <= sel_d;
      mem_id[wptr] <= sel_id;
    end
  end

  // Pointers and occupancy; 1-bit pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= 1'b0;
      rptr  <= 1'b0;
      count <= 2'd0;
    end else begin
      if (push) wptr <= ~wptr;
      if (pop)  rptr <= ~rptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Sticky error on any multi-hot grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      err_q <= 1'b0;
    else if (multi) err_q <= 1'b1;
  end

  // Head-of-queue view.
  always_comb begin
    out_valid_o = (count != 2'd0);
    out_data_o  = mem_d[rptr];
    out_id_o    = mem_id[rptr];
    level_o     = count;
    err_o       = err_q;
  end

endmodule

// File: tb/tb_arb_grant_mux.sv
// tb_arb_grant_mux: directed plus random stimulus against a
// queue-based reference model of the grant capture FIFO.
module tb_arb_grant_mux;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] gnt;
  logic [N*W-1:0] data;
  logic [N-1:0] ack;
  logic         ovalid;
  logic [W-1:0] odata;
  logic [1:0]   oid;
  logic         ordy;
  logic [1:0]   level;
  logic         err;

  typedef struct {
    int         id;
    logic [7:0] d;
  } ent_t;

  ent_t q[$];
  bit   m_err;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  arb_grant_mux #(.N(N), .W(W)) dut (
    .clk(clk),
    .reset(reset),
    .gnt_i(gnt),
    .data_i(data),
    .ack_o(ack),
    .out_valid_o(ovalid),
    .out_data_o(odata),
    .out_id_o(oid),
    .out_ready_i(ordy),
    .level_o(level),
    .err_o(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic [7:0] b3,
    input logic [7:0] b2, input logic [7:0] b1, input logic [7:0] b0);
    return {b3, b2, b1, b0};
  endfunction

  // One clock cycle: drive, check pre-edge view, advance model.
  task automatic cycle(input logic [3:0] g, input logic [31:0] d,
                       input logic r);
    int   cnt;
    int   ones;
    int   idx;
    bit   do_push;
    ent_t e;
    @(negedge clk);
    gnt  = g;
    data = d;
    ordy = r;
    #1;
    cnt  = q.size();
    ones = $countones(g);
    do_push = (ones == 1) && (cnt < 2);
    chk("ack", 32'(ack), do_push ? 32'(g) : 32'd0);
    chk("level", 32'(level), 32'(cnt));
    chk("valid", 32'(ovalid), 32'(cnt != 0));
    chk("err", 32'(err), 32'(m_err));
    if (cnt != 0) begin
      chk("head_data", 32'(odata), 32'(q[0].d));
      chk("head_id", 32'(oid), 32'(q[0].id));
    end
    @(posedge clk);
    if (cnt != 0 && r) void'(q.pop_front());
    if (do_push) begin
      idx = 0;
      for (int k = 0; k < N; k++) if (g[k]) idx = k;
      e.id = idx;
      e.d  = 8'((d >> (8 * idx)) & 32'hFF);
      q.push_back(e);
    end
    if (ones > 1) m_err = 1'b1;
  endtask

  task automatic check_reset_view();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(ovalid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_data", 32'(odata), 32'd0);
    chk("rst_id", 32'(oid), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
  endtask

  initial begin
    logic [3:0] g;
    logic [31:0] d;
    reset = 1'b1;
    gnt   = 4'b0100;
    data  = 32'hFFFF_FFFF;
    ordy  = 1'b0;
    m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_view();
    // Release between edges; first push on the very next edge.
    #1 reset = 1'b0;

    // Single push, one-cycle latency.
    cycle(4'b0100, pack(8'h00, 8'hA5, 8'h00, 8'h00), 1'b0);
    cycle(4'b0000, 32'h0, 1'b1);
    // Fill, blocked third grant, then drain in order.
    cycle(4'b0001, pack(8'h00, 8'h00, 8'h00, 8'h11), 1'b0);
    cycle(4'b1000, pack(8'h88, 8'h00, 8'h00, 8'h00), 1'b0);
    cycle(4'b0010, pack(8'h00, 8'h00, 8'h77, 8'h00), 1'b0);
    cycle(4'b0010, pack(8'h00, 8'h00, 8'h77, 8'h00), 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);
    // Simultaneous push and pop at level 1.
    cycle(4'b0001, pack(8'h00, 8'h00, 8'h00, 8'h5A), 1'b0);
    cycle(4'b0010, pack(8'h00, 8'h00, 8'h22, 8'h00), 1'b1);
    cycle(4'b0000, 32'h0, 1'b1);
    cycle(4'b0000, 32'h0, 1'b0);
    // Multi-hot grant sets sticky error.
    cycle(4'b0110, 32'h1234_5678, 1'b0);
    cycle(4'b0100, 32'h00C3_0000, 1'b0);
    cycle(4'b0001, 32'h0000_00D4, 1'b0);
    cycle(4'b0000, 32'h0, 1'b0);

    // Async reset with level 2, asserted between edges.
    chk("pre_rst_level", 32'(level), 32'd2);
    @(negedge clk);
    gnt = 4'b1000;
    #2 reset = 1'b1;
    #1;
    check_reset_view();
    q.delete();
    m_err = 1'b0;
    @(posedge clk);
    #2 reset = 1'b0;
    // Empty with ready high: no underflow, no stale output.
    repeat (5) cycle(4'b0000, 32'hDEAD_BEEF, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      int sel;
      sel = $urandom_range(0, 99);
      if (sel < 25)      g = 4'b0000;
      else if (sel < 97) g = 4'b0001 << $urandom_range(0, 3);
      else               g = 4'($urandom_range(0, 15));
      d = $urandom;
      cycle(g, d, 1'($urandom_range(0, 1)));
    end
    repeat (3) cycle(4'b0000, 32'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
